sys_bus_xbar: RTL and testbench

Single-clock, registered system-bus crossbar that decodes one master onto SN slave ports. It replaces the combinational fan-out with a transaction FSM. It adds a per-transaction ack timeout and an error response for unmapped slots. It generalises synchronised (broadcast) register writes to a parameter mask and a parameter register list. It sits between the PS-facing bus master and the peripheral register banks where all peripherals share the bus clock.

---
 rtl/sys_bus_xbar_pkg.sv | 24 ++
 rtl/sys_bus_tmo_cnt.sv | 34 +++
 rtl/sys_bus_xbar.sv | 159 +++++++++++++++
 tb/tb_sys_bus_xbar.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_xbar_pkg.sv
// Shared types and helpers for the system-bus crossbar and its timeout counter.
package sys_bus_xbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam int          TMO_W     = 16;
   localparam logic [31:0] ERR_RDATA = 32'h0;

   // sync_hit is the offset match against the synchronised register list;
   // a hit fans the write out to the source slot plus every mask slot.
   function automatic logic [31:0] target_mask(input logic [4:0]  slot,
                                               input logic        sync_hit,
                                               input logic [4:0]  sync_src,
                                               input logic [31:0] sync_mask);
      if (sync_hit) return (32'd1 << sync_src) | sync_mask;
      return 32'd1 << slot;
   endfunction

endpackage

// File: rtl/sys_bus_tmo_cnt.sv
// Loadable down-counter: start loads the limit, clr idles it, expire flags zero while armed.
module sys_bus_tmo_cnt #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         clr_i,
   input  logic [W-1:0] load_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic         active_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         cnt_q    <= load_i;
         active_q <= 1'b1;
      end else if (clr_i) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (active_q && cnt_q != '0) begin
         cnt_q    <= cnt_q - 1'b1;
      end
   end

   assign expire_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/sys_bus_xbar.sv
// Registered one-master / SN-slave bus crossbar with ack timeout, unmapped-slot
// error response and broadcast of synchronised register writes.
module sys_bus_xbar
   import sys_bus_xbar_pkg::*;
#(
   parameter int                         SN        = 16,
   parameter int                         SW        = 20,
   parameter int                         TMO       = 255,
   parameter int                         SYNC_SRC  = 0,
   parameter logic [SN-1:0]              SYNC_MASK = '0,
   parameter int                         SYNC_RN   = 6,
   parameter logic [SYNC_RN-1:0][SW-1:0] SYNC_REG  = '1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          m_addr_i,
   input  logic [31:0]          m_wdata_i,
   input  logic                 m_wen_i,
   input  logic                 m_ren_i,
   output logic [31:0]          m_rdata_o,
   output logic                 m_ack_o,
   output logic                 m_err_o,
   output logic [SN-1:0][31:0]  s_addr_o,
   output logic [SN-1:0][31:0]  s_wdata_o,
   output logic [SN-1:0]        s_wen_o,
   output logic [SN-1:0]        s_ren_o,
   input  logic [SN-1:0][31:0]  s_rdata_i,
   input  logic [SN-1:0]        s_ack_i,
   input  logic [SN-1:0]        s_err_i,
   output logic                 tmo_o
);

   localparam int SL = (SN > 1) ? $clog2(SN) : 1;

   state_t          state;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [SL-1:0]   slot_q;
   logic [SN-1:0]   tgt_q;
   logic [SN-1:0]   pend_q;
   logic            err_q;

   logic            req;
   logic [SL-1:0]   slot;
   logic            mapped;
   logic            sync_hit;
   logic [SN-1:0]   tgt;
   logic [SN-1:0]   pend_nx;
   logic            err_nx;
   logic            tmo_start;
   logic            tmo_exp;

   // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
   always_comb begin
      req      = m_wen_i | m_ren_i;
      slot     = m_addr_i[SW +: SL];
      mapped   = 32'(slot) < 32'(SN);
      sync_hit = 1'b0;
      if (m_wen_i && 32'(slot) == 32'(SYNC_SRC)) begin
         for (int i = 0; i < SYNC_RN; i++) begin
            if (m_addr_i[SW-1:0] == SYNC_REG[i]) sync_hit = 1'b1;
         end
      end
      tgt       = SN'(target_mask(5'(slot), sync_hit, 5'(SYNC_SRC), 32'(SYNC_MASK)));
      pend_nx   = pend_q & ~s_ack_i;
      err_nx    = err_q | (|(s_err_i & tgt_q));
      tmo_start = (state == ST_IDLE) && req && mapped;
   end

   sys_bus_tmo_cnt #(
      .W(TMO_W)
   ) u_tmo_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (tmo_start),
      .clr_i    (state == ST_RESP),
      .load_i   (TMO_W'(TMO)),
      .expire_o (tmo_exp)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         slot_q    <= '0;
         tgt_q     <= '0;
         pend_q    <= '0;
         err_q     <= 1'b0;
         s_wen_o   <= '0;
         s_ren_o   <= '0;
         m_ack_o   <= 1'b0;
         m_err_o   <= 1'b0;
         m_rdata_o <= '0;
         tmo_o     <= 1'b0;
      end else begin
         s_wen_o <= '0;
         s_ren_o <= '0;
         m_ack_o <= 1'b0;
         m_err_o <= 1'b0;
         tmo_o   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  addr_q  <= m_addr_i;
                  wdata_q <= m_wdata_i;
                  slot_q  <= slot;
                  err_q   <= 1'b0;
                  if (!mapped) begin
                     tgt_q  <= '0;
                     pend_q <= '0;
                     state  <= ST_RESP;
                  end else begin
                     tgt_q   <= tgt;
                     pend_q  <= tgt;
                     s_wen_o <= m_wen_i ? tgt : '0;
                     s_ren_o <= m_wen_i ? '0 : tgt;
                     state   <= ST_REQ;
                  end
               end
            end
            ST_REQ, ST_WAIT: begin
               pend_q <= pend_nx;
               err_q  <= err_nx;
               // Completion wins over expiry when the last ack lands on the final cycle.
               if (pend_nx == '0) begin
                  m_ack_o   <= 1'b1;
                  m_err_o   <= err_nx;
                  m_rdata_o <= s_rdata_i[slot_q];
                  state     <= ST_RESP;
               end else if (tmo_exp) begin
                  m_ack_o   <= 1'b1;
                  m_err_o   <= 1'b1;
                  m_rdata_o <= ERR_RDATA;
                  tmo_o     <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_RESP: begin
               // Unmapped requests enter here without an ack and spend one cycle producing it.
               if (!m_ack_o) begin
                  m_ack_o   <= 1'b1;
                  m_err_o   <= 1'b1;
                  m_rdata_o <= ERR_RDATA;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign s_addr_o  = {SN{addr_q}};
   assign s_wdata_o = {SN{wdata_q}};

endmodule

// File: tb/tb_sys_bus_xbar.sv
// Randomised and directed bench for sys_bus_xbar against a transaction-level model.
module tb_sys_bus_xbar;

   localparam int SN  = 5;
   localparam int SW  = 20;
   localparam int TMO = 4;
   localparam logic [SN-1:0]       SMASK = 5'b00110;
   localparam logic [1:0][SW-1:0]  SREG  = {20'hFFFFF, 20'h0000C};

   typedef struct {
      int           lat;
      logic         err;
      logic [31:0]  rdata;
      int           acks;
      int           tmos;
      int           tmo_lat;
      logic [SN-1:0] wen;
      logic [SN-1:0] ren;
      int           stray;
      int           addr_bad;
   } obs_t;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [31:0]        m_addr_i, m_wdata_i;
   logic               m_wen_i, m_ren_i;
   logic [31:0]        m_rdata_o;
   logic               m_ack_o, m_err_o, tmo_o;
   logic [SN-1:0][31:0] s_addr_o, s_wdata_o, s_rdata_i;
   logic [SN-1:0]      s_wen_o, s_ren_o, s_ack_i, s_err_i;

   int passes = 0;
   int total  = 0;
   int   dly  [SN] = '{-1, -1, -1, -1, -1};
   logic serr [SN] = '{0, 0, 0, 0, 0};
   int   cnt  [SN] = '{-1, -1, -1, -1, -1};

   sys_bus_xbar #(
      .SN(SN), .SW(SW), .TMO(TMO), .SYNC_SRC(0),
      .SYNC_MASK(SMASK), .SYNC_RN(2), .SYNC_REG(SREG)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wen_i(m_wen_i), .m_ren_i(m_ren_i),
      .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wen_o(s_wen_o), .s_ren_o(s_ren_o),
      .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .tmo_o(tmo_o)
   );

   always #5 clk_i = ~clk_i;

   // Slave responders: a strobe seen in cycle c produces an ack in cycle c+dly (dly<0 never acks).
   initial begin : slave_model
      s_ack_i = '0;
      s_err_i = '0;
      forever begin
         @(negedge clk_i);
         for (int i = 0; i < SN; i++) begin
            s_ack_i[i] = 1'b0;
            s_err_i[i] = 1'b0;
            if (rst_i) begin
               cnt[i] = -1;
            end else begin
               if (s_wen_o[i] | s_ren_o[i]) cnt[i] = dly[i];
               if (cnt[i] == 0) begin
                  s_ack_i[i] = 1'b1;
                  s_err_i[i] = serr[i];
                  cnt[i]     = -1;
               end else if (cnt[i] > 0) begin
                  cnt[i]--;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one request and observes the bus for a bounded window; poke>0 re-requests in that cycle.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wen, input logic ren, input int poke, output obs_t o);
      o = '{default: 0};
      @(negedge clk_i);
      m_addr_i = addr; m_wdata_i = wdata; m_wen_i = wen; m_ren_i = ren;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk_i);
         m_wen_i = (cyc == poke);
         m_ren_i = 1'b0;
         if (cyc == poke) m_addr_i = 32'h0010_0000;
         if (cyc == 1) begin
            o.wen = s_wen_o;
            o.ren = s_ren_o;
         end else begin
            o.stray += $countones(s_wen_o | s_ren_o);
         end
         if (o.lat == 0) begin
            for (int i = 0; i < SN; i++)
               if (s_addr_o[i] !== addr || s_wdata_o[i] !== wdata) o.addr_bad++;
         end
         if (m_ack_o) begin
            o.acks++;
            if (o.lat == 0) begin
               o.lat   = cyc;
               o.err   = m_err_o;
               o.rdata = m_rdata_o;
            end
         end
         if (tmo_o) begin
            o.tmos++;
            if (o.tmo_lat == 0) o.tmo_lat = cyc;
         end
         if (o.lat != 0 && cyc >= o.lat + 3) break;
      end
      m_wen_i = 1'b0;
      m_ren_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      m_addr_i = '0; m_wdata_i = '0; m_wen_i = 1'b0; m_ren_i = 1'b0;
      repeat (3) @(negedge clk_i);
      total++; if ({m_ack_o, m_err_o, tmo_o} !== 3'b0) $display("FAIL reset_flags: got %b want 000", {m_ack_o, m_err_o, tmo_o}); else passes++;
      total++; if (m_rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", m_rdata_o); else passes++;
      total++; if ({s_wen_o, s_ren_o} !== '0 || s_addr_o !== '0 || s_wdata_o !== '0) $display("FAIL reset_slave_bus: wen %b ren %b addr0 %h", s_wen_o, s_ren_o, s_addr_o[0]); else passes++;
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_read_slot3();
      obs_t o;
      dly[3] = 0; s_rdata_i[3] = 32'h1234_5678;
      run_txn(32'h0030_0010, 32'h0, 1'b0, 1'b1, 0, o);
      total++; if (o.lat !== 2) $display("FAIL read3_latency: got %0d want 2", o.lat); else passes++;
      total++; if (o.rdata !== 32'h1234_5678 || o.err !== 1'b0) $display("FAIL read3_data: got %h err %b want 12345678 err 0", o.rdata, o.err); else passes++;
      total++; if (o.ren !== 5'b01000 || o.wen !== 5'b0 || o.stray !== 0) $display("FAIL read3_strobe: ren %b wen %b stray %0d want 01000 00000 0", o.ren, o.wen, o.stray); else passes++;
   endtask

   task automatic test_broadcast();
      obs_t o;
      dly[0] = 0; dly[1] = 3; dly[2] = 1;
      run_txn(32'h0000_000C, 32'h0000_00A5, 1'b1, 1'b0, 0, o);
      total++; if (o.wen !== 5'b00111 || o.stray !== 0) $display("FAIL bcast_strobe: wen %b stray %0d want 00111 0", o.wen, o.stray); else passes++;
      total++; if (o.addr_bad !== 0) $display("FAIL bcast_addr_data: %0d bad port-cycles want 0", o.addr_bad); else passes++;
      total++; if (o.lat !== 5 || o.err !== 1'b0 || o.acks !== 1) $display("FAIL bcast_resp: lat %0d err %b acks %0d want 5 0 1", o.lat, o.err, o.acks); else passes++;
      run_txn(32'h0000_0010, 32'h0000_00A5, 1'b1, 1'b0, 0, o);
      total++; if (o.wen !== 5'b00001) $display("FAIL nobcast_strobe: wen %b want 00001", o.wen); else passes++;
      total++; if (o.lat !== 2 || o.err !== 1'b0) $display("FAIL nobcast_resp: lat %0d err %b want 2 0", o.lat, o.err); else passes++;
   endtask

   task automatic test_timeout();
      obs_t o;
      dly[2] = 5;
      run_txn(32'h0020_0000, 32'h0000_0077, 1'b1, 1'b0, 0, o);
      total++; if (o.lat !== TMO + 2 || o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL tmo_resp: lat %0d err %b rdata %h want %0d 1 0", o.lat, o.err, o.rdata, TMO + 2); else passes++;
      total++; if (o.tmos !== 1 || o.tmo_lat !== TMO + 2) $display("FAIL tmo_pulse: count %0d at %0d want 1 at %0d", o.tmos, o.tmo_lat, TMO + 2); else passes++;
      total++; if (o.acks !== 1) $display("FAIL tmo_late_ack: acks %0d want 1", o.acks); else passes++;
      dly[2] = TMO;
      run_txn(32'h0020_0000, 32'h0000_0078, 1'b1, 1'b0, 0, o);
      total++; if (o.lat !== TMO + 2 || o.err !== 1'b0 || o.tmos !== 0) $display("FAIL tmo_edge_ack: lat %0d err %b tmos %0d want %0d 0 0", o.lat, o.err, o.tmos, TMO + 2); else passes++;
   endtask

   task automatic test_unmapped();
      obs_t o;
      for (int i = 0; i < SN; i++) dly[i] = 0;
      run_txn(32'h0060_0000, 32'h0, 1'b0, 1'b1, 0, o);
      total++; if (o.lat !== 2 || o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL unmapped_resp: lat %0d err %b rdata %h want 2 1 0", o.lat, o.err, o.rdata); else passes++;
      total++; if (o.wen !== 5'b0 || o.ren !== 5'b0 || o.stray !== 0 || o.tmos !== 0) $display("FAIL unmapped_strobe: wen %b ren %b stray %0d tmos %0d want none", o.wen, o.ren, o.stray, o.tmos); else passes++;
   endtask

   task automatic test_reset_in_wait();
      obs_t o;
      int   extra_acks;
      dly[3] = 0; s_rdata_i[3] = 32'hCAFE_0003;
      run_txn(32'h0030_0000, 32'h0, 1'b0, 1'b1, 0, o);
      dly[1] = -1;
      @(negedge clk_i);
      m_addr_i = 32'h0010_0040; m_wdata_i = 32'h55; m_wen_i = 1'b1;
      @(negedge clk_i);
      m_wen_i = 1'b0;
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      total++; if ({m_ack_o, m_err_o, tmo_o} !== 3'b0 || m_rdata_o !== 32'h0) $display("FAIL rst_wait_master: ack %b err %b tmo %b rdata %h want all 0", m_ack_o, m_err_o, tmo_o, m_rdata_o); else passes++;
      total++; if ({s_wen_o, s_ren_o} !== '0 || s_addr_o !== '0 || s_wdata_o !== '0) $display("FAIL rst_wait_slave: addr0 %h wdata0 %h want 0", s_addr_o[0], s_wdata_o[0]); else passes++;
      @(negedge clk_i);
      rst_i = 1'b0;
      extra_acks = 0;
      repeat (TMO + 4) begin
         @(negedge clk_i);
         if (m_ack_o) extra_acks++;
      end
      total++; if (extra_acks !== 0) $display("FAIL rst_discard: %0d acks after reset want 0", extra_acks); else passes++;
      dly[3] = 1;
      run_txn(32'h0030_0004, 32'h0, 1'b0, 1'b1, 0, o);
      total++; if (o.lat !== 3 || o.rdata !== 32'hCAFE_0003 || o.err !== 1'b0) $display("FAIL rst_recover: lat %0d rdata %h err %b want 3 cafe0003 0", o.lat, o.rdata, o.err); else passes++;
   endtask

   task automatic test_busy_drop();
      obs_t o;
      dly[1] = 0; dly[3] = 2;
      run_txn(32'h0030_0000, 32'h0, 1'b0, 1'b1, 1, o);
      total++; if (o.acks !== 1 || o.lat !== 4 || o.stray !== 0 || o.wen !== 5'b0) $display("FAIL busy_req: acks %0d lat %0d stray %0d wen %b want 1 4 0 0", o.acks, o.lat, o.stray, o.wen); else passes++;
      run_txn(32'h0030_0000, 32'h0, 1'b0, 1'b1, 4, o);
      total++; if (o.acks !== 1 || o.stray !== 0) $display("FAIL busy_resp: acks %0d stray %0d want 1 0", o.acks, o.stray); else passes++;
   endtask

   task automatic test_random();
      obs_t          o;
      int            slot, worst, exp_lat, exp_tmos;
      logic          wen, to, exp_err;
      logic [19:0]   off;
      logic [31:0]   addr, wdata, exp_rd;
      logic [SN-1:0] tgt;
      for (int t = 0; t < 60; t++) begin
         slot  = int'($urandom_range(0, 7));
         wen   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       off = 20'h0000C;
            1:       off = 20'hFFFFF;
            default: off = 20'($urandom);
         endcase
         addr        = $urandom;
         addr[22:20] = 3'(slot);
         addr[19:0]  = off;
         wdata       = $urandom;
         for (int i = 0; i < SN; i++) begin
            dly[i]       = int'($urandom_range(0, 7)) - 1;
            serr[i]      = ($urandom_range(0, 7) == 0);
            s_rdata_i[i] = $urandom;
         end
         tgt = '0;
         if (slot < SN) begin
            if (wen && slot == 0 && (off == SREG[0] || off == SREG[1])) tgt = SMASK | 5'b00001;
            else tgt[slot] = 1'b1;
         end
         to = 1'b0; worst = 0; exp_err = 1'b0;
         for (int i = 0; i < SN; i++) begin
            if (tgt[i]) begin
               if (dly[i] < 0 || dly[i] > TMO) to = 1'b1;
               else begin
                  if (dly[i] > worst) worst = dly[i];
                  exp_err |= serr[i];
               end
            end
         end
         if (slot >= SN) begin
            exp_lat = 2; exp_err = 1'b1; exp_rd = 32'h0; exp_tmos = 0;
         end else if (to) begin
            exp_lat = TMO + 2; exp_err = 1'b1; exp_rd = 32'h0; exp_tmos = 1;
         end else begin
            exp_lat = worst + 2; exp_rd = s_rdata_i[slot]; exp_tmos = 0;
         end
         run_txn(addr, wdata, wen, !wen, 0, o);
         total++; if (o.lat !== exp_lat || o.acks !== 1) $display("FAIL rnd%0d_latency: lat %0d acks %0d want %0d 1", t, o.lat, o.acks, exp_lat); else passes++;
         total++; if (o.err !== exp_err) $display("FAIL rnd%0d_err: got %b want %b", t, o.err, exp_err); else passes++;
         if (!wen) begin
            total++; if (o.rdata !== exp_rd) $display("FAIL rnd%0d_rdata: got %h want %h", t, o.rdata, exp_rd); else passes++;
         end
         total++; if (o.wen !== (wen ? tgt : '0) || o.ren !== (wen ? '0 : tgt) || o.stray !== 0) $display("FAIL rnd%0d_strobe: wen %b ren %b stray %0d want tgt %b wr %b", t, o.wen, o.ren, o.stray, tgt, wen); else passes++;
         total++; if (o.tmos !== exp_tmos || o.addr_bad !== 0) $display("FAIL rnd%0d_tmo_addr: tmos %0d bad %0d want %0d 0", t, o.tmos, o.addr_bad, exp_tmos); else passes++;
      end
   endtask

   initial begin : main
      s_rdata_i = '0;
      test_reset();
      test_read_slot3();
      test_broadcast();
      test_timeout();
      test_unmapped();
      test_reset_in_wait();
      test_busy_drop();
      test_random();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
